// File: rtl/mem_bus_sequencer_pkg.sv
// Shared types, defaults and strobe decode for the external-memory bus sequencer.
package mem_bus_sequencer_pkg;

   typedef enum logic [1:0] {IDLE, ADDR, ACCESS, COMPLETE} mem_state_t;

   localparam int MEM_ADDR_CYCLES_DEF = 1;
   localparam int MEM_WAIT_DEF        = 2;

   typedef struct packed {
      logic busy;
      logic done;
      logic memEn;
      logic ale;
      logic nMe;
      logic nOe;
      logic nWe;
      logic enb;
   } mem_strobes_t;

   // The counter must hold both ADDR_CYCLES-1 and the largest wait count.
   function automatic int cntWidth(input int addrCycles, input int waitW);
      int w;
      w = $clog2(addrCycles);
      if (waitW > w) w = waitW;
      if (w < 1) w = 1;
      return w;
   endfunction

   function automatic mem_strobes_t decodeStrobes(input mem_state_t s, input logic wr);
      mem_strobes_t o;
      o = '{busy: 1'b0, done: 1'b0, memEn: 1'b0, ale: 1'b0,
            nMe: 1'b1, nOe: 1'b1, nWe: 1'b1, enb: 1'b0};
      case (s)
         ADDR: begin
            o.busy  = 1'b1;
            o.memEn = 1'b1;
            o.ale   = 1'b1;
            o.nMe   = 1'b0;
         end
         ACCESS: begin
            o.busy = 1'b1;
            o.nMe  = 1'b0;
            if (wr) begin
               o.nWe   = 1'b0;
               o.memEn = 1'b1;
            end else begin
               o.nOe = 1'b0;
            end
         end
         COMPLETE: begin
            o.busy = 1'b1;
            o.done = 1'b1;
            o.nMe  = 1'b0;
            if (wr) o.memEn = 1'b1;   // write data held one more cycle after nWE rises
            else begin
               o.nOe = 1'b0;
               o.enb = 1'b1;
            end
         end
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/mem_bus_sequencer_counter.sv
// Loadable down-counter that times the address and access phases.
module mem_cycle_counter #(
   parameter int W = 4
) (
   input  logic         Clock,
   input  logic         nReset,
   input  logic         Load,
   input  logic [W-1:0] LoadValue,
   input  logic         Dec,
   output logic         Zero
);

   logic [W-1:0] value;

   // NOTE: sequential state is written with non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset)             value <= '0;
      else if (Load)           value <= LoadValue;
      else if (Dec && !Zero)   value <= value - 1'b1;
   end

   assign Zero = (value == '0);

endmodule

// File: rtl/mem_bus_sequencer.sv
// External-memory bus cycle sequencer: ADDR -> ACCESS -> COMPLETE per Req/Done transaction.
// Optional `MEM_WAIT_PIN_EN adds the nWait stretch input and WaitStall indicator.
module mem_bus_sequencer
   import mem_bus_sequencer_pkg::*;
#(
   parameter int ADDR_CYCLES = MEM_ADDR_CYCLES_DEF,
   parameter int WAIT_W      = 4
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic              Req,
   input  logic              Write,
   input  logic [WAIT_W-1:0] WaitCycles,
   output logic              Busy,
   output logic              Done,
   output logic              MemEn,
   output logic              ALE,
   output logic              nME,
   output logic              nOE,
   output logic              nWE,
   output logic              ENB
`ifdef MEM_WAIT_PIN_EN
   ,
   input  logic              nWait,
   output logic              WaitStall
`endif
);

   localparam int CNT_W = cntWidth(ADDR_CYCLES, WAIT_W);

   mem_state_t        state, nextState;
   logic              writeLat, nextWrite;
   logic [WAIT_W-1:0] waitLat, nextWait;
   mem_strobes_t      strobes;
   logic              cntLoad, cntDec, cntZero, waitReady;
   logic [CNT_W-1:0]  cntLoadValue;

`ifdef MEM_WAIT_PIN_EN
   assign waitReady = nWait;
`else
   assign waitReady = 1'b1;
`endif

   mem_cycle_counter #(.W(CNT_W)) u_counter (
      .Clock     (Clock),
      .nReset    (nReset),
      .Load      (cntLoad),
      .LoadValue (cntLoadValue),
      .Dec       (cntDec),
      .Zero      (cntZero)
   );

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      nextState    = state;
      nextWrite    = writeLat;
      nextWait     = waitLat;
      cntLoad      = 1'b0;
      cntDec       = 1'b0;
      cntLoadValue = '0;
      case (state)
         IDLE, COMPLETE: begin
            if (Req) begin
               nextState    = ADDR;
               nextWrite    = Write;
               nextWait     = WaitCycles;
               cntLoad      = 1'b1;
               cntLoadValue = CNT_W'(ADDR_CYCLES - 1);
            end else begin
               nextState = IDLE;
            end
         end
         ADDR: begin
            if (cntZero) begin
               nextState    = ACCESS;
               cntLoad      = 1'b1;
               cntLoadValue = CNT_W'(waitLat);
            end else begin
               cntDec = 1'b1;
            end
         end
         ACCESS: begin
            if (!cntZero)       cntDec    = 1'b1;
            else if (waitReady) nextState = COMPLETE;
         end
         default: nextState = IDLE;
      endcase
   end

   // NOTE: strobes are decoded from the next state and registered, so pads see
   // glitch-free Moore outputs with no combinational path from Req/Write.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state    <= IDLE;
         writeLat <= 1'b0;
         waitLat  <= '0;
         strobes  <= decodeStrobes(IDLE, 1'b0);
`ifdef MEM_WAIT_PIN_EN
         WaitStall <= 1'b0;
`endif
      end else begin
         state    <= nextState;
         writeLat <= nextWrite;
         waitLat  <= nextWait;
         strobes  <= decodeStrobes(nextState, nextWrite);
`ifdef MEM_WAIT_PIN_EN
         WaitStall <= (state == ACCESS) && cntZero && !nWait;
`endif
      end
   end

   assign Busy  = strobes.busy;
   assign Done  = strobes.done;
   assign MemEn = strobes.memEn;
   assign ALE   = strobes.ale;
   assign nME   = strobes.nMe;
   assign nOE   = strobes.nOe;
   assign nWE   = strobes.nWe;
   assign ENB   = strobes.enb;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Bench for mem_bus_sequencer: a transaction-level phase model checked every cycle,
// plus directed transactions with hand-computed cycle counts.
module tb_mem_bus_sequencer;

`ifdef MEM_WAIT_PIN_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif
   localparam int AC0 = 1;
   localparam int AC1 = 3;

   logic       Clock, nReset;
   logic       req[2], wr[2], nWait[2], waitStall[2];
   logic [3:0] wc[2];
   logic       busy[2], done[2], memEn[2], ale[2], nMe[2], nOe[2], nWe[2], enb[2];
   logic [7:0] outs[2];

   int checks = 0;
   int errors = 0;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   mem_bus_sequencer #(.ADDR_CYCLES(AC0), .WAIT_W(4)) dut0 (
      .Clock(Clock), .nReset(nReset), .Req(req[0]), .Write(wr[0]), .WaitCycles(wc[0]),
      .Busy(busy[0]), .Done(done[0]), .MemEn(memEn[0]), .ALE(ale[0]),
      .nME(nMe[0]), .nOE(nOe[0]), .nWE(nWe[0]), .ENB(enb[0])
`ifdef MEM_WAIT_PIN_EN
      , .nWait(nWait[0]), .WaitStall(waitStall[0])
`endif
   );

   mem_bus_sequencer #(.ADDR_CYCLES(AC1), .WAIT_W(4)) dut1 (
      .Clock(Clock), .nReset(nReset), .Req(req[1]), .Write(wr[1]), .WaitCycles(wc[1]),
      .Busy(busy[1]), .Done(done[1]), .MemEn(memEn[1]), .ALE(ale[1]),
      .nME(nMe[1]), .nOE(nOe[1]), .nWE(nWe[1]), .ENB(enb[1])
`ifdef MEM_WAIT_PIN_EN
      , .nWait(nWait[1]), .WaitStall(waitStall[1])
`endif
   );

`ifndef MEM_WAIT_PIN_EN
   assign waitStall[0] = 1'b0;
   assign waitStall[1] = 1'b0;
`endif

   assign outs[0] = {busy[0], done[0], memEn[0], ale[0], nMe[0], nOe[0], nWe[0], enb[0]};
   assign outs[1] = {busy[1], done[1], memEn[1], ale[1], nMe[1], nOe[1], nWe[1], enb[1]};

   task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, d, act, exp, $time);
      end
   endtask

   // Model: position within the transaction; 1..ac is address, next accLen cycles access, then complete.
   bit mActive[2], mWr[2], mStall[2];
   int mPos[2], mAcc[2];

   function automatic int acOf(input int d);
      return (d == 0) ? AC0 : AC1;
   endfunction

   always @(posedge Clock or negedge nReset) begin
      for (int d = 0; d < 2; d++) begin
         if (!nReset) begin
            mActive[d] = 1'b0;
            mStall[d]  = 1'b0;
         end else if (!mActive[d] || mPos[d] == acOf(d) + mAcc[d] + 1) begin
            mStall[d]  = 1'b0;
            mActive[d] = req[d];
            if (req[d]) begin
               mPos[d] = 1;
               mWr[d]  = wr[d];
               mAcc[d] = 1 + int'(wc[d]);
            end
         end else begin
            mStall[d] = 1'b0;
            if (STALL_EN && mPos[d] == acOf(d) + mAcc[d] && !nWait[d]) begin
               mAcc[d]++;
               mStall[d] = 1'b1;
            end
            mPos[d]++;
         end
      end
   end

   // Bit order: Busy Done MemEn ALE nME nOE nWE ENB
   function automatic logic [7:0] expOut(input int d);
      if (!mActive[d])                     return 8'b0000_1110;
      if (mPos[d] <= acOf(d))              return 8'b1011_0110;
      if (mPos[d] <= acOf(d) + mAcc[d])    return mWr[d] ? 8'b1010_0100 : 8'b1000_0010;
      return mWr[d] ? 8'b1110_0110 : 8'b1100_0011;
   endfunction

   always @(negedge Clock) begin
      for (int d = 0; d < 2; d++) begin
         check("model_outs", d, 32'(outs[d]), 32'(expOut(d)));
         check("wait_stall", d, 32'(waitStall[d]), 32'(mStall[d]));
         check("noe_nwe_excl", d, 32'(nOe[d] | nWe[d]), 32'd1);
      end
   end

   task automatic runTxn(input int d, input logic w, input int wcv, input int stallCycles,
                         input bit scramble, output int doneCyc, output int aleCnt,
                         output int nOeCnt, output int nWeCnt, output int enbCnt,
                         output int memWeCnt, output int stallCnt);
      doneCyc = -1; aleCnt = 0; nOeCnt = 0; nWeCnt = 0; enbCnt = 0; memWeCnt = 0; stallCnt = 0;
      req[d] = 1'b1; wr[d] = w; wc[d] = 4'(wcv); nWait[d] = (stallCycles == 0);
      for (int c = 1; c <= 40; c++) begin
         @(negedge Clock);
         aleCnt   += int'(ale[d]);
         nOeCnt   += int'(!nOe[d]);
         nWeCnt   += int'(!nWe[d]);
         enbCnt   += int'(enb[d]);
         memWeCnt += int'(!nWe[d] && memEn[d]);
         stallCnt += int'(waitStall[d]);
         if (scramble && c == 1) begin
            wr[d] = ~w;
            wc[d] = wc[d] + 4'd5;
         end
         if (stallCycles > 0 && c == acOf(d) + 1 + wcv + stallCycles) nWait[d] = 1'b1;
         if (done[d]) begin
            doneCyc = c;
            req[d] = 1'b0; wr[d] = 1'b0; wc[d] = 4'd0;
            break;
         end
      end
      nWait[d] = 1'b1;
   endtask

   int dc, al, oe, we, en, mw, st, d1, d2;
   bit busyAll;

   initial begin
      nReset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0; wr[d] = 1'b0; wc[d] = 4'd0; nWait[d] = 1'b1;
      end
      repeat (3) @(negedge Clock);
      nReset = 1'b1;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         @(negedge Clock);
         check("idle_outs", 0, 32'(outs[0]), 32'h0E);
         check("idle_outs", 1, 32'(outs[1]), 32'h0E);
      end

      // Default read, WaitCycles = 2, inputs scrambled mid-transaction
      runTxn(0, 1'b0, 2, 0, 1'b1, dc, al, oe, we, en, mw, st);
      check("rd2_done_cycle", 0, 32'(dc), 32'd5);
      check("rd2_ale_cycles", 0, 32'(al), 32'd1);
      check("rd2_noe_cycles", 0, 32'(oe), 32'd4);
      check("rd2_enb_cycles", 0, 32'(en), 32'd1);
      check("rd2_nwe_cycles", 0, 32'(we), 32'd0);
      @(negedge Clock);
      check("rd2_back_idle", 0, 32'(busy[0]), 32'd0);

      // Write, WaitCycles = 0, ADDR_CYCLES = 3
      runTxn(1, 1'b1, 0, 0, 1'b1, dc, al, oe, we, en, mw, st);
      check("wr0_done_cycle", 1, 32'(dc), 32'd5);
      check("wr0_ale_cycles", 1, 32'(al), 32'd3);
      check("wr0_nwe_cycles", 1, 32'(we), 32'd1);
      check("wr0_memen_nwe", 1, 32'(mw), 32'd1);
      check("wr0_noe_cycles", 1, 32'(oe), 32'd0);
      @(negedge Clock);

      // Back-to-back reads, WaitCycles = 1, Req held
      req[0] = 1'b1; wr[0] = 1'b0; wc[0] = 4'd1;
      d1 = -1; d2 = -1; busyAll = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge Clock);
         busyAll &= busy[0];
         if (done[0]) begin
            if (d1 < 0) d1 = c;
            else begin
               d2 = c;
               req[0] = 1'b0;
               break;
            end
         end
      end
      check("b2b_first_done", 0, 32'(d1), 32'd4);
      check("b2b_second_done", 0, 32'(d2), 32'd8);
      check("b2b_busy_held", 0, 32'(busyAll), 32'd1);
      @(negedge Clock);

      // Reset in the second ACCESS cycle of a write
      req[0] = 1'b1; wr[0] = 1'b1; wc[0] = 4'd3;
      repeat (3) @(negedge Clock);
      check("rst_pre_nwe", 0, 32'(nWe[0]), 32'd0);
      #2 nReset = 1'b0;
      #1 check("rst_async_outs", 0, 32'(outs[0]), 32'h0E);
      req[0] = 1'b0; wr[0] = 1'b0; wc[0] = 4'd0;
      @(negedge Clock);
      nReset = 1'b1;
      @(negedge Clock);
      check("rst_after_idle", 0, 32'(outs[0]), 32'h0E);
      runTxn(0, 1'b0, 0, 0, 1'b0, dc, al, oe, we, en, mw, st);
      check("rst_new_rd_done", 0, 32'(dc), 32'd3);
      @(negedge Clock);

      // Maximum wait count, no wrap
      runTxn(0, 1'b0, 15, 0, 1'b0, dc, al, oe, we, en, mw, st);
      check("rd15_done_cycle", 0, 32'(dc), 32'd18);
      check("rd15_noe_cycles", 0, 32'(oe), 32'd17);
      @(negedge Clock);

`ifdef MEM_WAIT_PIN_EN
      // nWait held low three cycles at the end of ACCESS
      runTxn(0, 1'b0, 0, 3, 1'b0, dc, al, oe, we, en, mw, st);
      check("stall_done_cycle", 0, 32'(dc), 32'd6);
      check("stall_cycles", 0, 32'(st), 32'd3);
      check("stall_noe_cycles", 0, 32'(oe), 32'd5);
      @(negedge Clock);
`endif

      repeat (2) @(negedge Clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_bus_sequencer.md
Name: mem_bus_sequencer

Overview:
- Parametrised external-memory bus cycle sequencer that replaces the hard-wired 5-step fetch timing inside the control unit.
- Serves fetch, load and store requests from the core controller over a Req/Done handshake.
- Generates pad and memory-map strobes (MemEn, ALE, nME, nOE, nWE, ENB) with programmable address-phase length and per-transaction wait states.
- Sits between control and the pad ring/memory map.

Parameters:
- ADDR_CYCLES, 1, address phase length in cycles; legal range 1..8.
- WAIT_W, 4, width of the runtime wait-state input; 0..2^WAIT_W-1 extra access cycles.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- nReset  input  1  asynchronous, active-low reset.
- Req  input  1  transaction request from the core controller; held high until Done.
- Write  input  1  1 = store cycle, 0 = read (fetch/load); sampled only when Req is accepted.
- WaitCycles  input  WAIT_W  extra access-phase cycles; sampled only when Req is accepted.
- Busy  output  1  high from acceptance until the end of COMPLETE.
- Done  output  1  one-cycle pulse in COMPLETE; read data is valid on the pad during this cycle.
- MemEn  output  1  pad output enable (address, or write data).
- ALE  output  1  address latch enable.
- nME  output  1  memory enable, active low.
- nOE  output  1  output enable, active low.
- nWE  output  1  write enable, active low.
- ENB  output  1  pad input enable (read capture).

Behaviour:
- States: IDLE, ADDR, ACCESS, COMPLETE.
- Outputs are Moore decodes of registered state and latched Write; no combinational path from inputs to outputs.
- Reset (asynchronous, and also mid-transaction):
  - state = IDLE, counter = 0, latched Write = 0.
  - Busy = 0, Done = 0, MemEn = 0, ALE = 0, ENB = 0.
  - nME = 1, nOE = 1, nWE = 1.
  - The transaction is dropped; there is no resume after reset.
- IDLE:
  - All outputs at reset values.
  - Req = 1 at an edge: latch Write and WaitCycles, load counter = ADDR_CYCLES-1, go to ADDR.
- ADDR:
  - MemEn = 1, ALE = 1, nME = 0, Busy = 1.
  - Counter decrements each cycle; at 0, load counter = latched WaitCycles and go to ACCESS.
- ACCESS:
  - nME = 0, Busy = 1.
  - Read: nOE = 0. Write: nWE = 0 and MemEn = 1.
  - Counter decrements; at 0, go to COMPLETE. Length is 1 + WaitCycles.
- COMPLETE:
  - Done = 1, Busy = 1, nME = 0.
  - Read: nOE = 0, ENB = 1. Write: nWE = 1, MemEn = 1 (data hold).
  - If Req = 1, re-sample Write and WaitCycles and go directly to ADDR (back-to-back, no idle bubble). Otherwise go to IDLE.
- Latency:
  - Done is high in cycle ADDR_CYCLES + 1 + WaitCycles + 1 counted after the accepting edge.
  - Defaults with WaitCycles = 2 give 5 cycles, identical to the legacy fetch timing.
- Req and Write are ignored in ADDR and ACCESS. WaitCycles changes mid-transaction have no effect.
- WaitCycles = 0 gives a 1-cycle ACCESS. WaitCycles = max gives 2^WAIT_W cycles, with no counter wrap.
- nOE and nWE are never low in the same cycle; a verification assertion checks this.

Optional Feature:
- Macro: MEM_WAIT_PIN_EN.
- Defined:
  - Adds input nWait (1 bit, active low, synchronous to Clock).
  - In ACCESS with counter = 0 and nWait = 0, state holds ACCESS and strobes stay asserted.
  - COMPLETE follows the first cycle with counter = 0 and nWait = 1.
  - Adds output WaitStall (1 bit, reset 0), high in each extended cycle.
- Not defined: no nWait or WaitStall ports; ACCESS length is fixed at 1 + WaitCycles.

Decomposition:
- Shared opcodes package holds:
  - typedef enum mem_state_t {IDLE, ADDR, ACCESS, COMPLETE};
  - constants MEM_ADDR_CYCLES_DEF = 1, MEM_WAIT_DEF = 2.
- One sub-module: mem_cycle_counter, a loadable down-counter with load, value and zero flag.
  - Width = max($clog2(ADDR_CYCLES), WAIT_W), minimum 1.

Test Plan:
- Reset then idle, no Req → all outputs at reset values for 10 cycles; Busy = 0, nME = nOE = nWE = 1.
- Read, Write = 0, WaitCycles = 2, defaults → states ADDR, ACCESS×3, COMPLETE; ALE high in cycle 1 only, nOE low in cycles 2-5, Done and ENB high in cycle 5, then IDLE.
- Write, WaitCycles = 0, ADDR_CYCLES = 3 → ALE high 3 cycles, nWE low 1 cycle with MemEn = 1, nWE back to 1 with Done high in cycle 5; nOE stays 1 throughout.
- Back-to-back: Req held high for two reads with WaitCycles = 1 → Done pulses 4 cycles apart; no IDLE cycle between transactions; Busy stays high.
- nReset pulsed low in the second ACCESS cycle of a write → nWE and nME go to 1 immediately (asynchronous); after release the block is in IDLE and accepts a new Req normally.
- MEM_WAIT_PIN_EN defined, WaitCycles = 0, nWait low for 3 cycles → ACCESS lasts 4 cycles, WaitStall high 3 cycles, Done follows the first cycle with nWait = 1.
